// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding and default geometry for the instruction cache
//   IDLE/MEM_READ FSM states; default ADDR_W/INDEX_BITS/WOFF_BITS with derived
//   tag, block-address and line widths.
package icache_pkg;
    typedef enum logic {IDLE, MEM_READ} state_t;
    localparam int IC_ADDR_W     = 10;
    localparam int IC_INDEX_BITS = 3;
    localparam int IC_WOFF_BITS  = 2;
    localparam int IC_TAG_BITS   = IC_ADDR_W - IC_INDEX_BITS - IC_WOFF_BITS - 2;
    localparam int IC_BLK_ADDR_W = IC_ADDR_W - IC_WOFF_BITS - 2;
    localparam int IC_LINE_W     = 32 << IC_WOFF_BITS;
endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: tag/valid/data storage for a direct-mapped cache
//   i_clk, i_rst         clock, synchronous active-high reset (clears valid bits only)
//   i_ridx -> o_valid/o_tag/o_data   combinational read port
//   i_we, i_widx, i_wtag, i_wdata    synchronous write port (sets valid)
module icache_line_array #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 3,
    parameter int LINE_W     = 128
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [INDEX_BITS-1:0] i_ridx,
    output logic                  o_valid,
    output logic [TAG_BITS-1:0]   o_tag,
    output logic [LINE_W-1:0]     o_data,
    input  logic                  i_we,
    input  logic [INDEX_BITS-1:0] i_widx,
    input  logic [TAG_BITS-1:0]   i_wtag,
    input  logic [LINE_W-1:0]     i_wdata
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [LINE_W-1:0]   r_data [LINES];

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_valid <= '0;
        else if (i_we)
            r_valid[i_widx] <= 1'b1;
    end

    // Tag/data need no reset: they are only trusted once the valid bit is set.
    always_ff @(posedge i_clk) begin
        if (i_we && !i_rst) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end

    assign o_valid = r_valid[i_ridx];
    assign o_tag   = r_tag[i_ridx];
    assign o_data  = r_data[i_ridx];
endmodule

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped instruction cache between cpu fetch and block-wide memory
//   CLK, RESET                         clock, synchronous active-high reset
//   PC -> INSTRUCTION, BUSYWAIT         cpu fetch port (hits combinational, misses stall)
//   IMEM_READ, IMEM_ADDRESS,
//   IMEM_READDATA, IMEM_BUSYWAIT        block read port to instruction memory
//   HIT_COUNT, MISS_COUNT               saturating statistics, only with INSTR_CACHE_STATS_EN
module instr_cache
    import icache_pkg::*;
#(
    parameter int ADDR_W     = IC_ADDR_W,
    parameter int INDEX_BITS = IC_INDEX_BITS,
    parameter int WOFF_BITS  = IC_WOFF_BITS
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [31:0]                   PC,
    output logic [31:0]                   INSTRUCTION,
    output logic                          BUSYWAIT,
    output logic                          IMEM_READ,
    output logic [ADDR_W-WOFF_BITS-3:0]   IMEM_ADDRESS,
    input  logic [(32<<WOFF_BITS)-1:0]    IMEM_READDATA,
    input  logic                          IMEM_BUSYWAIT
`ifdef INSTR_CACHE_STATS_EN
    ,
    output logic [31:0]                   HIT_COUNT,
    output logic [31:0]                   MISS_COUNT
`endif
);
    localparam int TAG_BITS   = ADDR_W - INDEX_BITS - WOFF_BITS - 2;
    localparam int BLK_ADDR_W = ADDR_W - WOFF_BITS - 2;
    localparam int LINE_W     = 32 << WOFF_BITS;

    state_t                  r_state, w_next;
    logic [BLK_ADDR_W-1:0]   r_blk_addr;
    logic [WOFF_BITS-1:0]    w_word;
    logic [INDEX_BITS-1:0]   w_index;
    logic [TAG_BITS-1:0]     w_tag, w_line_tag;
    logic                    w_valid, w_hit, w_fill;
    logic [LINE_W-1:0]       w_line_data;
    logic                    w_unused;

    // Bits above ADDR_W are dropped so fetches wrap modulo the instruction space.
    assign w_word   = PC[WOFF_BITS+1:2];
    assign w_index  = PC[WOFF_BITS+INDEX_BITS+1:WOFF_BITS+2];
    assign w_tag    = PC[ADDR_W-1:ADDR_W-TAG_BITS];
    assign w_unused = ^{PC[31:ADDR_W], PC[1:0]};

    icache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS),
        .LINE_W     (LINE_W)
    ) u_lines (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_ridx  (w_index),
        .o_valid (w_valid),
        .o_tag   (w_line_tag),
        .o_data  (w_line_data),
        .i_we    (w_fill),
        .i_widx  (r_blk_addr[INDEX_BITS-1:0]),
        .i_wtag  (r_blk_addr[BLK_ADDR_W-1:INDEX_BITS]),
        .i_wdata (IMEM_READDATA)
    );

    assign w_hit        = w_valid && (w_line_tag == w_tag);
    assign IMEM_ADDRESS = r_blk_addr;

    always_comb begin
        w_next      = r_state;
        w_fill      = 1'b0;
        BUSYWAIT    = 1'b0;
        IMEM_READ   = 1'b0;
        INSTRUCTION = 32'd0;
        if (!RESET) begin
            if (r_state == IDLE) begin
                if (w_hit) begin
                    INSTRUCTION = w_line_data[{w_word, 5'd0} +: 32];
                end else begin
                    BUSYWAIT = 1'b1;
                    w_next   = MEM_READ;
                end
            end else begin
                IMEM_READ = 1'b1;
                BUSYWAIT  = 1'b1;
                if (!IMEM_BUSYWAIT) begin
                    w_fill = 1'b1;
                    w_next = IDLE;
                end
            end
        end
    end

    // The fill target is captured at miss time; later PC changes cannot redirect it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && !w_hit)
                r_blk_addr <= {w_tag, w_index};
        end
    end

`ifdef INSTR_CACHE_STATS_EN
    logic        r_just_filled;
    logic [31:0] r_hit_cnt, r_miss_cnt;

    // The re-lookup right after a fill is the completion of a miss, not a new hit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_just_filled <= 1'b0;
            r_hit_cnt     <= '0;
            r_miss_cnt    <= '0;
        end else begin
            r_just_filled <= w_fill;
            if (r_state == IDLE && w_hit && !r_just_filled && r_hit_cnt != '1)
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (r_state == IDLE && !w_hit && r_miss_cnt != '1)
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign HIT_COUNT  = r_hit_cnt;
    assign MISS_COUNT = r_miss_cnt;
`endif
endmodule
